// File: rtl/al422_write_sched.sv
// al422_write_sched
//
// Write-side frame scheduler for the AL422 frame FIFO feeding the LED panel
// scan engine. Bytes arrive from the host receiver over valid/ready; each frame
// starts with a write reset (/WRST low across one WCK rise) and then exactly
// FRAME_BYTES bytes are clocked into the FIFO, two in_clk cycles per byte.
// With LOCK=1 the write reset waits for the read side's frame-start strobe so
// both FIFO pointers are re-based together.
//
// Ports
//   in_clk          clock, rising edge
//   in_nrst         asynchronous active-low reset
//   host_data[7:0]  byte from host receiver
//   host_valid      host_data valid
//   host_sof        host_data is the first byte of a frame
//   host_ready      byte accepted when host_valid & host_ready
//   rd_frame_start  read-side frame-start pulse (one cycle)
//   clr_err         synchronous clear of sync_err
//   al_data[7:0]    AL422 write data
//   al_wck          AL422 WCK
//   al_nwe          AL422 /WE
//   al_nwrst        AL422 /WRST
//   frame_done      one-cycle pulse after the last byte of a frame
//   busy            FSM is not in IDLE
//   sync_err        sticky framing error (dropped byte or mid-frame sof)
//
// State table
//   state  | meaning
//   IDLE   | waiting for a sof byte; non-sof bytes are dropped
//   SYNC   | first byte held, waiting for rd_frame_start (LOCK=1 only)
//   WRST_A | /WRST low, WCK low
//   WRST_B | /WRST low, WCK high (the single write-reset clock)
//   WR_A   | data set up, WCK low
//   WR_B   | WCK high, byte clocked; next byte accepted here
//   WAIT   | host stalled mid-frame, WCK low, data held
//   DONE   | frame_done pulse

module al422_write_sched #(
    parameter int FRAME_BYTES = 2048,
    parameter bit LOCK        = 1'b1
) (
    input  logic       in_clk,
    input  logic       in_nrst,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    input  logic       host_sof,
    output logic       host_ready,
    input  logic       rd_frame_start,
    input  logic       clr_err,
    output logic [7:0] al_data,
    output logic       al_wck,
    output logic       al_nwe,
    output logic       al_nwrst,
    output logic       frame_done,
    output logic       busy,
    output logic       sync_err
);

    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_WRST_A, S_WRST_B, S_WR_A, S_WR_B, S_WAIT, S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [7:0]    hold, hold_nx;
    logic [7:0]    data_nx;
    logic          err_set;
    logic          xfer;

    assign xfer = host_valid & host_ready;

    always_comb begin
        state_nx = state;
        count_nx = count;
        hold_nx  = hold;
        data_nx  = al_data;
        err_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    if (host_sof) begin
                        hold_nx  = host_data;
                        state_nx = LOCK ? S_SYNC : S_WRST_A;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            S_SYNC:   if (rd_frame_start) state_nx = S_WRST_A;
            S_WRST_A: state_nx = S_WRST_B;
            S_WRST_B: begin
                state_nx = S_WR_A;
                data_nx  = hold;
            end
            S_WR_A:   state_nx = S_WR_B;
            S_WR_B, S_WAIT: begin
                if (state == S_WR_B) begin
                    count_nx = count + 1'b1;
                    state_nx = S_WAIT;
                end
                // host_ready is low in WR_B on the last byte, so xfer cannot fire there
                if (state == S_WR_B && count == LAST) begin
                    state_nx = S_DONE;
                end else if (xfer) begin
                    if (host_sof) begin
                        // Restart: the new write reset discards the partial frame
                        err_set  = 1'b1;
                        hold_nx  = host_data;
                        state_nx = LOCK ? S_SYNC : S_WRST_A;
                    end else begin
                        data_nx  = host_data;
                        state_nx = S_WR_A;
                    end
                end
            end
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (state_nx == S_WRST_A && state != S_WRST_A) begin
            count_nx = '0;
        end
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state      <= S_IDLE;
            count      <= '0;
            hold       <= '0;
            al_data    <= '0;
            host_ready <= 1'b0;
            al_wck     <= 1'b0;
            al_nwe     <= 1'b1;
            al_nwrst   <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            hold       <= hold_nx;
            al_data    <= data_nx;
            host_ready <= (state_nx == S_IDLE) || (state_nx == S_WAIT) ||
                          (state_nx == S_WR_B && count_nx != LAST);
            al_wck     <= (state_nx == S_WRST_B) || (state_nx == S_WR_B);
            al_nwe     <= !(state_nx inside {S_WRST_A, S_WRST_B, S_WR_A, S_WR_B, S_WAIT});
            al_nwrst   <= !(state_nx inside {S_WRST_A, S_WRST_B});
            frame_done <= (state_nx == S_DONE);
            busy       <= (state_nx != S_IDLE);
            sync_err   <= err_set | (sync_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_al422_write_sched.sv
module tb_al422_write_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // u_d0: LOCK=0, u_d1: LOCK=1, both FRAME_BYTES=4
    logic [7:0] d0_hdata = '0, d1_hdata = '0;
    logic d0_valid = 0, d0_sof = 0, d0_clr = 0, d0_rfs = 0;
    logic d1_valid = 0, d1_sof = 0, d1_clr = 0, d1_rfs = 0;
    logic d0_ready, d0_wck, d0_nwe, d0_nwrst, d0_done, d0_busy, d0_err;
    logic d1_ready, d1_wck, d1_nwe, d1_nwrst, d1_done, d1_busy, d1_err;
    logic [7:0] d0_data, d1_data;

    al422_write_sched #(.FRAME_BYTES(4), .LOCK(1'b0)) u_d0 (
        .in_clk(clk), .in_nrst(rst_n), .host_data(d0_hdata), .host_valid(d0_valid),
        .host_sof(d0_sof), .host_ready(d0_ready), .rd_frame_start(d0_rfs),
        .clr_err(d0_clr), .al_data(d0_data), .al_wck(d0_wck), .al_nwe(d0_nwe),
        .al_nwrst(d0_nwrst), .frame_done(d0_done), .busy(d0_busy), .sync_err(d0_err));

    al422_write_sched #(.FRAME_BYTES(4), .LOCK(1'b1)) u_d1 (
        .in_clk(clk), .in_nrst(rst_n), .host_data(d1_hdata), .host_valid(d1_valid),
        .host_sof(d1_sof), .host_ready(d1_ready), .rd_frame_start(d1_rfs),
        .clr_err(d1_clr), .al_data(d1_data), .al_wck(d1_wck), .al_nwe(d1_nwe),
        .al_nwrst(d1_nwrst), .frame_done(d1_done), .busy(d1_busy), .sync_err(d1_err));

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard events: 0x0xx byte written, 0x100 write reset, 0x200 frame_done
    localparam logic [9:0] EV_WRST = 10'h100;
    localparam logic [9:0] EV_DONE = 10'h200;
    logic [9:0] sb_q[$];

    task automatic sb_check(input logic [9:0] ev);
        if (sb_q.size() == 0) chk("sb_unexpected", {22'd0, ev}, 32'h3ff);
        else chk("sb_event", {22'd0, ev}, {22'd0, sb_q.pop_front()});
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        sb_q.push_back(EV_WRST);
        sb_q.push_back({2'b00, b0});
        sb_q.push_back({2'b00, b1});
        sb_q.push_back({2'b00, b2});
        sb_q.push_back({2'b00, b3});
        sb_q.push_back(EV_DONE);
    endtask

    // Timing checks active only while the host streams without gaps
    bit cont = 0;
    int sof_cyc = 0;

    initial begin : mon_d0
        logic prev_wck;
        int wrst_len, nwe_len, last_wr;
        bit have_wr;
        prev_wck = 0; wrst_len = 0; nwe_len = 0; last_wr = 0; have_wr = 0;
        forever begin
            @(negedge clk);
            if (d0_wck && !prev_wck) begin
                if (!d0_nwrst) begin
                    sb_check(EV_WRST);
                    have_wr = 0;
                end else begin
                    chk("we_at_wck", {31'd0, d0_nwe}, 32'd0);
                    sb_check({2'b00, d0_data});
                    if (cont && have_wr) chk("wck_spacing", cyc - last_wr, 2);
                    have_wr = 1;
                    last_wr = cyc;
                end
            end
            if (d0_done) begin
                sb_check(EV_DONE);
                if (cont) chk("done_latency", cyc - sof_cyc, 10);
            end
            if (!d0_nwrst) wrst_len++;
            else if (wrst_len != 0) begin
                chk("wrst_len", wrst_len, 2);
                wrst_len = 0;
            end
            if (!d0_nwe) nwe_len++;
            else if (nwe_len != 0) begin
                if (cont) chk("nwe_len", nwe_len, 10);
                nwe_len = 0;
            end
            prev_wck = d0_wck;
        end
    end

    logic [7:0] d1_cap[$];
    int d1_dones = 0;
    initial begin : mon_d1
        logic prev_wck;
        prev_wck = 0;
        forever begin
            @(negedge clk);
            if (d1_wck && !prev_wck && d1_nwrst) d1_cap.push_back(d1_data);
            if (d1_done) d1_dones++;
            prev_wck = d1_wck;
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge
    task automatic send(input bit sel, input logic [7:0] d, input logic s);
        int n;
        n = 0;
        if (sel) begin d1_valid = 1; d1_hdata = d; d1_sof = s; end
        else     begin d0_valid = 1; d0_hdata = d; d0_sof = s; end
        while (!(sel ? d1_ready : d0_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", {31'd0, n < 100}, 32'd1);
        @(negedge clk);
        if (sel) begin d1_valid = 0; d1_sof = 0; end
        else     begin d0_valid = 0; d0_sof = 0; end
    endtask

    task automatic wait_sb();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || d0_busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb_q.size(), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", {31'd0, d0_ready}, 0);
        chk("rst_data", {24'd0, d0_data}, 0);
        chk("rst_wck", {31'd0, d0_wck}, 0);
        chk("rst_nwe", {31'd0, d0_nwe}, 1);
        chk("rst_nwrst", {31'd0, d0_nwrst}, 1);
        chk("rst_done", {31'd0, d0_done}, 0);
        chk("rst_busy", {31'd0, d0_busy}, 0);
        chk("rst_err", {31'd0, d0_err}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, d0_ready}, 1);

        // Plain frame, continuous valid
        cont = 1;
        push_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        send(0, 8'hA0, 1);
        sof_cyc = cyc;
        send(0, 8'hA1, 0);
        send(0, 8'hA2, 0);
        send(0, 8'hA3, 0);
        wait_sb();
        cont = 0;
        chk("err_clean", {31'd0, d0_err}, 0);

        // Bytes without sof in IDLE are dropped
        send(0, 8'h55, 0);
        chk("drop_nwe", {31'd0, d0_nwe}, 1);
        send(0, 8'h66, 0);
        chk("drop_busy", {31'd0, d0_busy}, 0);
        chk("drop_nwrst", {31'd0, d0_nwrst}, 1);
        chk("drop_err", {31'd0, d0_err}, 1);
        d0_clr = 1;
        @(negedge clk);
        d0_clr = 0;
        chk("clr_err", {31'd0, d0_err}, 0);
        d0_clr = 1;
        send(0, 8'h77, 0);
        d0_clr = 0;
        chk("set_wins", {31'd0, d0_err}, 1);
        d0_clr = 1;
        @(negedge clk);
        d0_clr = 0;

        // Mid-frame sof aborts and restarts
        sb_q.push_back(EV_WRST);
        sb_q.push_back({2'b00, 8'hA0});
        sb_q.push_back({2'b00, 8'hA1});
        push_frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        send(0, 8'hA0, 1);
        send(0, 8'hA1, 0);
        send(0, 8'hB0, 1);
        chk("abort_err", {31'd0, d0_err}, 1);
        send(0, 8'hB1, 0);
        send(0, 8'hB2, 0);
        send(0, 8'hB3, 0);
        wait_sb();
        d0_clr = 1;
        @(negedge clk);
        d0_clr = 0;

        // Host stall after the second byte
        push_frame(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        send(0, 8'hC0, 1);
        send(0, 8'hC1, 0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("wait_wck", {31'd0, d0_wck}, 0);
            chk("wait_data", {24'd0, d0_data}, 32'hC1);
            chk("wait_nwe", {31'd0, d0_nwe}, 0);
            @(negedge clk);
        end
        send(0, 8'hC2, 0);
        send(0, 8'hC3, 0);
        wait_sb();

        // Reset during WR_B of byte 2
        sb_q.push_back(EV_WRST);
        sb_q.push_back({2'b00, 8'hD0});
        sb_q.push_back({2'b00, 8'hD1});
        send(0, 8'hD0, 1);
        send(0, 8'hD1, 0);
        @(negedge clk);
        chk("pre_rst_wck", {31'd0, d0_wck}, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_wck", {31'd0, d0_wck}, 0);
        chk("mid_rst_nwe", {31'd0, d0_nwe}, 1);
        chk("mid_rst_nwrst", {31'd0, d0_nwrst}, 1);
        chk("mid_rst_busy", {31'd0, d0_busy}, 0);
        chk("mid_rst_ready", {31'd0, d0_ready}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        push_frame(8'hE0, 8'hE1, 8'hE2, 8'hE3);
        send(0, 8'hE0, 1);
        send(0, 8'hE1, 0);
        send(0, 8'hE2, 0);
        send(0, 8'hE3, 0);
        wait_sb();

        // LOCK=1: rd_frame_start during the sof handshake is ignored
        d1_rfs = 1;
        send(1, 8'hF0, 1);
        d1_rfs = 0;
        for (int i = 0; i < 10; i++) begin
            chk("sync_ready", {31'd0, d1_ready}, 0);
            chk("sync_nwrst", {31'd0, d1_nwrst}, 1);
            chk("sync_busy", {31'd0, d1_busy}, 1);
            @(negedge clk);
        end
        d1_rfs = 1;
        @(negedge clk);
        d1_rfs = 0;
        chk("lock_nwrst", {31'd0, d1_nwrst}, 0);
        send(1, 8'hF1, 0);
        send(1, 8'hF2, 0);
        send(1, 8'hF3, 0);
        for (int n = 0; n < 40 && d1_dones == 0; n++) @(negedge clk);
        chk("lock_done", d1_dones, 1);
        chk("lock_cnt", d1_cap.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < d1_cap.size()) chk("lock_byte", {24'd0, d1_cap[i]}, 32'hF0 + i);
        end

        @(negedge clk);
        chk("sb_left", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
